heichips25_nibble_mem_bridge: RTL and testbench
===============================================

# heichips25_nibble_mem_bridge

Fabric-side bridge that terminates the 4-bit serial memory link driven by the Snitch wrapper. It reassembles nibble-serial write requests into 32-bit words with byte enables and issues single-word transactions on an SRAM-style memory port. For reads, it returns the 32-bit read data to the core as eight nibbles followed by a one-cycle commit beat. It sits in the eFPGA directly downstream of the wrapper pins and upstream of the program/data memory.

## Interface
Parameters:
- AddrWidth, 8, width of the request address (core address bits [12:5]).
- DataWidth, 32, memory word width; fixed at 8 nibbles.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_nibble_i  in  4  request data nibble, LSB-first.
- req_addr_i  in  AddrWidth  request address; latched on first beat.
- req_write_i  in  1  1 = write (8 beats), 0 = read (1 beat).
- req_strb_i  in  1  strobe bit for the current nibble.
- req_valid_i  in  1  request beat valid.
- req_ready_o  out  1  request beat accepted.
- rsp_nibble_o  out  4  response nibble, LSB-first.
- rsp_valid_o  out  1  response beat valid; also the commit pulse.
- rsp_ready_i  in  1  response beat accepted.
- rsp_last_o  out  1  marks the 8th data nibble.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  AddrWidth  word address.
- mem_we_o  out  1  write enable.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  write data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

## Operation
- FSM states: IDLE, COLLECT, MEM_REQ, MEM_WAIT, RSP, COMMIT.
- **IDLE**
  - req_ready_o=1.
  - A beat is accepted when req_valid_i=1 in this state.
  - On acceptance, latch addr and write.
  - write=1: nibble→word[3:0], strb→sbit[0], cnt=1, go COLLECT.
  - write=0: go MEM_REQ; nibble and strb are ignored.
- **COLLECT**
  - req_ready_o=1.
  - Each accepted beat stores nibble→word[4·cnt+3:4·cnt] and strb→sbit[cnt], then cnt++.
  - req_addr_i and req_write_i are ignored in this state.
  - After the 8th beat (cnt==7 accepted), go MEM_REQ.
- **MEM_REQ**
  - mem_req_o=1; mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are held stable until mem_gnt_i.
  - mem_be_o[i] = sbit[2i] | sbit[2i+1].
  - Reads drive mem_be_o=4'hF.
  - On grant: write → IDLE (posted, no response); read → MEM_WAIT.
- **MEM_WAIT**
  - mem_rvalid_i is sampled only in this state.
  - On rvalid, capture mem_rdata_i, set k=0, go RSP.
- **RSP**
  - rsp_valid_o=1, rsp_nibble_o=rdata[4k+3:4k], rsp_last_o=(k==7).
  - On rsp_ready_i: k++. After k==7 is accepted, go COMMIT.
- **COMMIT**
  - rsp_valid_o=1 for exactly one cycle; rsp_ready_i is ignored.
  - rsp_last_o=0, rsp_nibble_o=0.
  - Then go IDLE.
- req_ready_o=0 in MEM_REQ, MEM_WAIT, RSP and COMMIT.
  - The link carries one transaction at a time; new requests stall until the bridge returns to IDLE.
- Outputs not driven by the current state are 0.

## Timing
- Reset (rst_i=1 at a clock edge): state=IDLE, counters=0, data/strobe registers=0.
- Reset values of outputs: req_ready_o=1, all rsp_* =0, all mem_* =0.
- Reset mid-transaction drops the transaction silently:
  - a partial write is never issued;
  - a pending mem_rvalid_i after reset is ignored.
- Read latency with zero-wait memory: request beat accepted at cycle T → mem_req_o at T+1.
- If mem_gnt_i is high at T+1 and mem_rvalid_i is high at T+2:
  - first rsp_valid_o at T+3;
  - last nibble no earlier than T+10;
  - commit pulse one cycle after the last nibble is accepted.
- Write: the 8th beat accepted at cycle T → mem_req_o at T+1. With a same-cycle grant, req_ready_o returns at T+2.
- rsp_nibble_o and rsp_last_o are held stable while rsp_valid_o=1 and rsp_ready_i=0.
- mem_rvalid_i in the same cycle as mem_gnt_i is not supported; memory must respond ≥1 cycle after the grant.

## Structure
- heichips25_bridge_pkg holds:
  - the bridge_state_e enum;
  - NibblesPerWord=8;
  - a mem_req_t packed struct {addr, we, be, wdata}, shared with the SRAM model.
- One sub-module: heichips25_nibble_shift (8×4-bit indexed load/readout register with counter), instantiated twice, once for request assembly and once for response serialisation.

## Test plan
- Write 0xDEADBEEF to addr 0x12, all strobes=1, ready every cycle → one mem_req_o with we=1, addr=0x12, wdata=0xDEADBEEF, be=4'hF; no rsp_valid_o.
- Write 0x11223344 with strobes 1,1,0,0,0,0,1,1 → be=4'b1001, wdata=0x11223344.
- Read addr 0x05, memory returns 0xCAFEF00D → nibbles D,0,0,F,E,F,A,C; rsp_last_o only on C; then a single-cycle commit pulse.
- Same read with rsp_ready_i toggling 1,0,0,1… → each nibble held stable until accepted; none skipped or duplicated.
- mem_gnt_i delayed 5 cycles → mem_* outputs stable throughout; req_ready_o=0 until IDLE.
- rst_i asserted after 4 of 8 write beats → no mem_req_o. A following full write of 0x0000000F issues wdata=0x0000000F.

Source files
------------

// File: rtl/heichips25_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heichips25_bridge_pkg
// Purpose  : Shared types and constants for the nibble-serial memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package heichips25_bridge_pkg;

    localparam int unsigned c_NIBBLES_PER_WORD = 8;
    localparam int unsigned c_ADDR_WIDTH       = 8;
    localparam int unsigned c_DATA_WIDTH       = 4 * c_NIBBLES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RSP      = 3'd4,
        COMMIT   = 3'd5
    } bridge_state_e;

    // Single-word SRAM transaction, also used by the SRAM model.
    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] addr;
        logic                    we;
        logic [3:0]              be;
        logic [c_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/heichips25_nibble_shift.sv
`default_nettype none
// ============================================================================
// Module   : heichips25_nibble_shift
// Purpose  : Indexed nibble register with per-nibble bit and a wrapping
//            counter; loads serially or in parallel, reads out serially.
// Revision : 1.0 - initial release
// ============================================================================
module heichips25_nibble_shift
    import heichips25_bridge_pkg::*;
#(
    parameter int unsigned NIBBLES = c_NIBBLES_PER_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [3:0]           i_nibble,
    input  logic                 i_bit,
    input  logic                 i_load,
    input  logic [4*NIBBLES-1:0] i_word,
    input  logic                 i_step,
    output logic [4*NIBBLES-1:0] o_word,
    output logic [NIBBLES-1:0]   o_bits,
    output logic [3:0]           o_nibble,
    output logic                 o_last
);

    localparam int unsigned c_CW = $clog2(NIBBLES);

    logic [4*NIBBLES-1:0] r_word;
    logic [NIBBLES-1:0]   r_bits;
    logic [c_CW-1:0]      r_cnt;

    // Counter wraps to zero after the last nibble, so no explicit clear is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_bits <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_cnt  <= '0;
        end else if (i_wr) begin
            r_word[{r_cnt, 2'b00} +: 4] <= i_nibble;
            r_bits[r_cnt]               <= i_bit;
            r_cnt                       <= r_cnt + c_CW'(1);
        end else if (i_step) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_word   = r_word;
    assign o_bits   = r_bits;
    assign o_nibble = r_word[{r_cnt, 2'b00} +: 4];
    assign o_last   = (r_cnt == c_CW'(NIBBLES - 1));

endmodule
`default_nettype wire

// File: rtl/heichips25_nibble_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : heichips25_nibble_mem_bridge
// Purpose  : Terminates the 4-bit serial memory link and issues single-word
//            SRAM transactions; reads return as 8 nibbles plus a commit beat.
// Revision : 1.0 - initial release
// ============================================================================
module heichips25_nibble_mem_bridge
    import heichips25_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            req_nibble_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic                  req_strb_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [3:0]            rsp_nibble_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_last_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    bridge_state_e         r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;

    logic                  w_latch, w_req_wr, w_rsp_load, w_rsp_step;
    logic [c_DATA_WIDTH-1:0]       w_req_word, w_rsp_word;
    logic [c_NIBBLES_PER_WORD-1:0] w_req_bits, w_rsp_bits;
    logic [3:0]            w_req_nibble, w_rsp_nibble, w_be;
    logic                  w_req_last, w_rsp_last;
    mem_req_t              w_mem;
    logic                  w_unused;

    heichips25_nibble_shift u_req_shift (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_wr     (w_req_wr),
        .i_nibble (req_nibble_i),
        .i_bit    (req_strb_i),
        .i_load   (1'b0),
        .i_word   ('0),
        .i_step   (1'b0),
        .o_word   (w_req_word),
        .o_bits   (w_req_bits),
        .o_nibble (w_req_nibble),
        .o_last   (w_req_last)
    );

    heichips25_nibble_shift u_rsp_shift (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_wr     (1'b0),
        .i_nibble (4'h0),
        .i_bit    (1'b0),
        .i_load   (w_rsp_load),
        .i_word   (c_DATA_WIDTH'(mem_rdata_i)),
        .i_step   (w_rsp_step),
        .o_word   (w_rsp_word),
        .o_bits   (w_rsp_bits),
        .o_nibble (w_rsp_nibble),
        .o_last   (w_rsp_last)
    );

    assign w_unused = ^{w_rsp_word, w_rsp_bits, w_req_nibble};

    // A byte is enabled when either of its two nibble strobes was set.
    for (genvar gi = 0; gi < 4; gi++) begin : g_be
        assign w_be[gi] = w_req_bits[2*gi] | w_req_bits[2*gi+1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr  <= req_addr_i;
                r_write <= req_write_i;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_req_wr     = 1'b0;
        w_rsp_load   = 1'b0;
        w_rsp_step   = 1'b0;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_nibble_o = 4'h0;
        rsp_last_o   = 1'b0;
        mem_req_o    = 1'b0;
        w_mem        = '0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_latch  = 1'b1;
                    w_req_wr = req_write_i;
                    w_next   = req_write_i ? COLLECT : MEM_REQ;
                end
            end
            COLLECT: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_req_wr = 1'b1;
                    if (w_req_last) w_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_o   = 1'b1;
                w_mem.addr  = c_ADDR_WIDTH'(r_addr);
                w_mem.we    = r_write;
                w_mem.be    = r_write ? w_be : 4'hF;
                w_mem.wdata = r_write ? w_req_word : '0;
                if (mem_gnt_i) w_next = r_write ? IDLE : MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    w_rsp_load = 1'b1;
                    w_next     = RSP;
                end
            end
            RSP: begin
                rsp_valid_o  = 1'b1;
                rsp_nibble_o = w_rsp_nibble;
                rsp_last_o   = w_rsp_last;
                if (rsp_ready_i) begin
                    w_rsp_step = 1'b1;
                    if (w_rsp_last) w_next = COMMIT;
                end
            end
            COMMIT: begin
                rsp_valid_o = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_addr_o  = ADDR_WIDTH'(w_mem.addr);
    assign mem_we_o    = w_mem.we;
    assign mem_be_o    = w_mem.be;
    assign mem_wdata_o = DATA_WIDTH'(w_mem.wdata);

endmodule
`default_nettype wire

// File: tb/tb_heichips25_nibble_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_heichips25_nibble_mem_bridge
// Purpose  : Self-checking bench for the nibble memory bridge with an SRAM
//            array model and randomized transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heichips25_nibble_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_nibble;
    logic [7:0]  req_addr;
    logic        req_write, req_strb, req_valid, req_ready;
    logic [3:0]  rsp_nibble;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem_model [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    heichips25_nibble_mem_bridge dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_nibble_i (req_nibble),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_strb_i   (req_strb),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .rsp_nibble_o (rsp_nibble),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_last_o   (rsp_last),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full write transaction; the SRAM model is updated byte-wise by the enables.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int gnt_dly, input string tag);
        logic [3:0] exp_be;
        int         w;
        bit         seen_rsp;
        seen_rsp = 1'b0;
        for (int i = 0; i < 4; i++) exp_be[i] = ((strb >> (2 * i)) & 8'd3) != 0;
        for (int i = 0; i < 8; i++) begin
            req_valid  = 1'b1;
            req_write  = (i == 0) ? 1'b1 : 1'($urandom);
            req_addr   = (i == 0) ? addr : 8'($urandom);
            req_nibble = data[4*i +: 4];
            req_strb   = strb[i];
            w = 0;
            while (!req_ready && w < 20) begin tick; w++; end
            n_tests++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s beat%0d ready: got %b want 1", tag, i, req_ready);
                req_valid = 1'b0;
                return;
            end
            tick;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        w = 0;
        while (!mem_req && w < 20) begin tick; w++; end
        n_tests++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL %s req_latency: got %0d extra cycles want 0", tag, w);
        end
        for (int d = 0; d <= gnt_dly; d++) begin
            n_tests++;
            if ({mem_req, mem_addr, mem_we, mem_be, mem_wdata, req_ready} !==
                {1'b1, addr, 1'b1, exp_be, data, 1'b0}) begin
                n_fail++;
                $display("FAIL %s mem_fields cyc%0d: got req=%b a=%h we=%b be=%b wd=%h rdy=%b want 1 %h 1 %b %h 0",
                         tag, d, mem_req, mem_addr, mem_we, mem_be, mem_wdata, req_ready,
                         addr, exp_be, data);
            end
            if (rsp_valid) seen_rsp = 1'b1;
            mem_gnt = (d == gnt_dly);
            tick;
        end
        mem_gnt = 1'b0;
        n_tests++;
        if ({req_ready, mem_req, rsp_valid, seen_rsp} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s post_grant: got rdy=%b req=%b rspv=%b seen_rsp=%b want 1 0 0 0",
                     tag, req_ready, mem_req, rsp_valid, seen_rsp);
        end
        for (int i = 0; i < 4; i++)
            if (exp_be[i]) mem_model[addr][8*i +: 8] = data[8*i +: 8];
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic do_read(input logic [7:0] addr, input int gnt_dly, input int rv_dly,
                           input int rmode, input bit chk_lat, input string tag);
        logic [31:0] exp;
        int          w, got, cyc;
        bit          done;
        exp        = mem_model[addr];
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = addr;
        req_nibble = 4'($urandom);
        req_strb   = 1'($urandom);
        w = 0;
        while (!req_ready && w < 20) begin tick; w++; end
        tick;
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        w = 0;
        while (!mem_req && w < 20) begin tick; w++; end
        n_tests++;
        if (mem_req !== 1'b1 || (chk_lat && w != 0)) begin
            n_fail++;
            $display("FAIL %s req_latency: got req=%b after %0d cycles want 1 after 0", tag, mem_req, w);
        end
        for (int d = 0; d <= gnt_dly; d++) begin
            n_tests++;
            if ({mem_req, mem_addr, mem_we, mem_be, req_ready} !== {1'b1, addr, 1'b0, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL %s mem_fields cyc%0d: got req=%b a=%h we=%b be=%b rdy=%b want 1 %h 0 1111 0",
                         tag, d, mem_req, mem_addr, mem_we, mem_be, req_ready, addr);
            end
            mem_gnt = (d == gnt_dly);
            tick;
        end
        mem_gnt = 1'b0;
        for (int d = 0; d < rv_dly; d++) begin
            n_tests++;
            if ({rsp_valid, mem_req, req_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL %s wait_idle: got rspv=%b req=%b rdy=%b want 0 0 0", tag, rsp_valid, mem_req, req_ready);
            end
            tick;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = exp;
        tick;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        got  = 0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 200) begin
            case (rmode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rsp_ready = 1'($urandom);
            endcase
            n_tests++;
            if (got < 8) begin
                if ({rsp_valid, rsp_nibble, rsp_last} !== {1'b1, exp[4*got +: 4], got == 7}) begin
                    n_fail++;
                    $display("FAIL %s nibble%0d: got v=%b n=%h l=%b want 1 %h %b",
                             tag, got, rsp_valid, rsp_nibble, rsp_last, exp[4*got +: 4], got == 7);
                end
                if (rsp_ready) got++;
                tick;
            end else begin
                if ({rsp_valid, rsp_nibble, rsp_last} !== 6'b1_0000_0) begin
                    n_fail++;
                    $display("FAIL %s commit: got v=%b n=%h l=%b want 1 0 0", tag, rsp_valid, rsp_nibble, rsp_last);
                end
                tick;
                n_tests++;
                if ({rsp_valid, req_ready} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL %s after_commit: got rspv=%b rdy=%b want 0 1", tag, rsp_valid, req_ready);
                end
                done = 1'b1;
            end
            cyc++;
        end
        rsp_ready = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %0d nibbles want 8 plus commit", tag, got);
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_nibble, rsp_last, mem_req, mem_addr, mem_we, mem_be, mem_wdata} !==
            {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b rspv=%b n=%h l=%b req=%b a=%h we=%b be=%b wd=%h want rdy=1 rest 0",
                     req_ready, rsp_valid, rsp_nibble, rsp_last, mem_req, mem_addr, mem_we, mem_be, mem_wdata);
        end
    endtask

    task automatic test_write;
        do_write(8'h12, 32'hDEADBEEF, 8'hFF, 0, "write_full");
        do_write(8'h34, 32'h11223344, 8'b1100_0011, 0, "write_strb");
    endtask

    task automatic test_read;
        mem_model[8'h05] = 32'hCAFEF00D;
        do_read(8'h05, 0, 0, 0, 1'b1, "read_basic");
        do_read(8'h05, 0, 0, 1, 1'b1, "read_backpressure");
    endtask

    task automatic test_gnt_delay;
        do_write(8'h40, 32'hA5A55A5A, 8'b0011_1100, 5, "write_gnt5");
        do_read(8'h40, 5, 3, 2, 1'b1, "read_gnt5");
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_addr   = 8'h77;
            req_nibble = 4'hF;
            req_strb   = 1'b1;
            tick;
        end
        req_valid = 1'b0;
        apply_reset;
        for (int i = 0; i < 12; i++) begin
            if (mem_req) seen = 1'b1;
            tick;
        end
        n_tests++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_write: got mem_req_seen=%b rdy=%b want 0 1", seen, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h05;
        tick;
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick;
        mem_gnt   = 1'b0;
        apply_reset;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick;
        mem_rvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got rsp_valid_seen=%b want 0", seen);
        end
        do_write(8'h77, 32'h0000000F, 8'hFF, 0, "write_after_reset");
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        for (int t = 0; t < 24; t++) begin
            a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 8'($urandom), $urandom_range(0, 3), "rand_write");
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), 2, 1'b0, "rand_read");
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_nibble = 4'h0;
        req_addr   = 8'h00;
        req_write  = 1'b0;
        req_strb   = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
        test_reset;
        test_write;
        test_read;
        test_gnt_delay;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
